pipe_hazard_ctl: RTL and testbench

- Parametrised pipeline hazard/interrupt controller for the MIPS-class core.
- Sits beside the ID stage. Decodes the per-cycle hazard command from ID into flush/hold controls for the ID->RA and RA->EXEC registers and a PC pre-select.
- Adds configurable multiply and divide latencies and NUM_IRQ prioritised interrupt lines with a masked, non-nesting service flag.

---
 rtl/pipe_hazard_ctl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctl_irq_prio_enc.sv | 23 ++
 rtl/pipe_hazard_ctl.sv | 203 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared encodings for the pipeline hazard/interrupt controller: ID hazard
// commands, controller states and the one-hot PC pre-select values.
package pipe_hazard_ctl_pkg;

    typedef enum logic [2:0] {
        CmdNop = 3'd0,
        CmdCur = 3'd1,
        CmdMul = 3'd2,
        CmdDiv = 3'd3,
        CmdRet = 3'd4,
        CmdLd  = 3'd5,
        CmdNoi = 3'd6,
        CmdRsv = 3'd7
    } id_cmd_e;

    typedef enum logic [2:0] {
        StRst  = 3'd0,
        StIdle = 3'd1,
        StNoi  = 3'd2,
        StCur  = 3'd3,
        StLd   = 3'd4,
        StRet  = 3'd5,
        StIrq  = 3'd6,
        StDly  = 3'd7
    } hz_state_e;

    localparam logic [3:0] PC_IGN = 4'b0001;
    localparam logic [3:0] PC_KEP = 4'b0010;
    localparam logic [3:0] PC_IRQ = 4'b0100;
    localparam logic [3:0] PC_RST = 4'b1000;

endpackage

// File: rtl/pipe_hazard_ctl_irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins. Shared with the CP0
// cause logic, so it carries no controller-specific state.
module pipe_hazard_ctl_irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic [IDW-1:0]     o_id,
    output logic               o_valid
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        o_valid = |i_req;
        o_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard/interrupt controller beside the ID stage. Turns the per-cycle
// hazard command into flush/hold controls and a PC pre-select, stalls for
// multiply/divide latency and arbitrates non-nesting interrupts.
// Optional: define PIPE_HAZARD_PERF_EN to add the o_stall_cnt perf counter.
module pipe_hazard_ctl
    import pipe_hazard_ctl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 34,
    parameter int unsigned DIV_LAT = 36,
    parameter int          NUM_IRQ = 4,
    parameter int          IDW     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         i_id_cmd,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_irq_mask,
    output logic               o_iack,
    output logic [IDW-1:0]     o_irq_id,
    output logic               o_ins_clr,
    output logic               o_ins_cls,
    output logic               o_ctl_clr,
    output logic               o_ctl_cls,
    output logic               o_ex_ctl_clr,
    output logic [3:0]         o_pc_prectl,
    output logic               o_is_nop,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0]        o_stall_cnt,
`endif
    output logic               o_busy
);

    // Counter load values; latency >= 1 so these never underflow.
    localparam logic [5:0] MulLoad = 6'(MUL_LAT - 1);
    localparam logic [5:0] DivLoad = 6'(DIV_LAT - 1);

    hz_state_e          r_state;
    hz_state_e          w_state_d;
    logic [5:0]         r_dly_cnt;
    logic [5:0]         w_dly_cnt_d;
    logic               r_iack;
    logic [IDW-1:0]     r_irq_id;
    logic [NUM_IRQ-1:0] w_pending;
    logic [IDW-1:0]     w_enc_id;
    logic               w_enc_valid;
    logic               w_irq_take;
    logic               w_dispatch;

    assign w_pending = i_irq & ~i_irq_mask;

    pipe_hazard_ctl_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDW     (IDW)
    ) u_prio_enc (
        .i_req   (w_pending),
        .o_id    (w_enc_id),
        .o_valid (w_enc_valid)
    );

    // State and stall counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StRst;
            r_dly_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_dly_cnt <= w_dly_cnt_d;
        end
    end

    // Next-state logic; a pending interrupt in IDLE pre-empts the command.
    always_comb begin
        w_state_d   = r_state;
        w_dly_cnt_d = r_dly_cnt;
        w_irq_take  = 1'b0;
        w_dispatch  = 1'b0;
        unique case (r_state)
            StRst:  w_state_d = StIdle;
            StIdle: begin
                if (w_enc_valid && !r_iack) begin
                    w_state_d  = StIrq;
                    w_irq_take = 1'b1;
                end else begin
                    w_dispatch = 1'b1;
                end
            end
            StNoi:  w_dispatch = 1'b1;
            StCur:  w_state_d = StNoi;
            StLd:   w_state_d = StIdle;
            StIrq:  w_state_d = StIdle;
            StRet:  w_state_d = StIdle;
            StDly: begin
                if (r_dly_cnt == 6'd0) begin
                    w_state_d = StIdle;
                end else begin
                    w_dly_cnt_d = r_dly_cnt - 6'd1;
                end
            end
            default: w_state_d = StRst;
        endcase
        if (w_dispatch) begin
            case (id_cmd_e'(i_id_cmd))
                CmdNoi:  w_state_d = StNoi;
                CmdCur:  w_state_d = StCur;
                CmdMul: begin
                    w_state_d   = StDly;
                    w_dly_cnt_d = MulLoad;
                end
                CmdDiv: begin
                    w_state_d   = StDly;
                    w_dly_cnt_d = DivLoad;
                end
                CmdLd:   w_state_d = StLd;
                CmdRet:  w_state_d = StRet;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Service flag: set on IRQ entry, cleared while in RET; id held until next take.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iack   <= 1'b0;
            r_irq_id <= '0;
        end else if (w_irq_take) begin
            r_iack   <= 1'b1;
            r_irq_id <= w_enc_id;
        end else if (r_state == StRet) begin
            r_iack   <= 1'b0;
        end
    end

    assign o_iack   = r_iack;
    assign o_irq_id = r_irq_id;

    // Moore decode of pipeline controls from the current state.
    always_comb begin
        o_ins_clr    = 1'b0;
        o_ins_cls    = 1'b0;
        o_ctl_clr    = 1'b0;
        o_ctl_cls    = 1'b0;
        o_ex_ctl_clr = 1'b0;
        o_pc_prectl  = PC_IGN;
        o_is_nop     = 1'b0;
        o_busy       = 1'b0;
        unique case (r_state)
            StRst: begin
                o_ins_clr    = 1'b1;
                o_ctl_clr    = 1'b1;
                o_ex_ctl_clr = 1'b1;
                o_pc_prectl  = PC_RST;
                o_is_nop     = 1'b1;
            end
            StCur: begin
                o_ins_cls    = 1'b1;
                o_ctl_cls    = 1'b1;
                o_ex_ctl_clr = 1'b1;
                o_pc_prectl  = PC_KEP;
                o_is_nop     = 1'b1;
            end
            StLd: begin
                o_ins_clr    = 1'b1;
                o_ctl_clr    = 1'b1;
                o_pc_prectl  = PC_KEP;
            end
            StIrq: begin
                o_ins_clr    = 1'b1;
                o_ctl_clr    = 1'b1;
                o_ex_ctl_clr = 1'b1;
                o_pc_prectl  = PC_IRQ;
            end
            StDly: begin
                o_ins_clr    = 1'b1;
                o_ctl_clr    = 1'b1;
                o_pc_prectl  = PC_KEP;
                o_is_nop     = 1'b1;
                o_busy       = 1'b1;
            end
            default: begin
                o_pc_prectl  = PC_IGN;
            end
        endcase
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall_inc;

    assign w_stall_inc = (o_busy || o_ins_cls || o_ins_clr) && (r_state != StRst);

    // Saturating count of stalled/flushed cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl. Each step drives inputs, queues the
// expected output snapshot for the following clock, then pops and checks it.
module tb_pipe_hazard_ctl;

    localparam int S_RST  = 0;
    localparam int S_IDLE = 1;
    localparam int S_NOI  = 2;
    localparam int S_CUR  = 3;
    localparam int S_LD   = 4;
    localparam int S_RET  = 5;
    localparam int S_IRQ  = 6;
    localparam int S_DLY  = 7;

    logic       clk;
    logic       rst;
    logic [2:0] id_cmd;
    logic [3:0] irq;
    logic [3:0] irq_mask;
    logic       iack;
    logic [1:0] irq_id;
    logic       ins_clr, ins_cls, ctl_clr, ctl_cls, ex_ctl_clr;
    logic [3:0] pc_prectl;
    logic       is_nop;
    logic       busy;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [14:0] exp_q[$];
    string       tag_q[$];

    pipe_hazard_ctl #(
        .MUL_LAT (34),
        .DIV_LAT (36),
        .NUM_IRQ (4),
        .IDW     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_id_cmd     (id_cmd),
        .i_irq        (irq),
        .i_irq_mask   (irq_mask),
        .o_iack       (iack),
        .o_irq_id     (irq_id),
        .o_ins_clr    (ins_clr),
        .o_ins_cls    (ins_cls),
        .o_ctl_clr    (ctl_clr),
        .o_ctl_cls    (ctl_cls),
        .o_ex_ctl_clr (ex_ctl_clr),
        .o_pc_prectl  (pc_prectl),
        .o_is_nop     (is_nop),
`ifdef PIPE_HAZARD_PERF_EN
        .o_stall_cnt  (stall_cnt),
`endif
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output snapshot: {ins_clr,ins_cls,ctl_clr,ctl_cls,ex_ctl_clr,pc[3:0],is_nop,busy,iack,id[1:0]}
    function automatic logic [14:0] exp_vec(input int st, input logic ia, input logic [1:0] id);
        logic [10:0] d;
        case (st)
            S_RST:   d = {5'b10101, 4'd8, 1'b1, 1'b0};
            S_CUR:   d = {5'b01011, 4'd2, 1'b1, 1'b0};
            S_LD:    d = {5'b10100, 4'd2, 1'b0, 1'b0};
            S_IRQ:   d = {5'b10101, 4'd4, 1'b0, 1'b0};
            S_DLY:   d = {5'b10100, 4'd2, 1'b1, 1'b1};
            default: d = {5'b00000, 4'd1, 1'b0, 1'b0};
        endcase
        return {d, ia, id};
    endfunction

    task automatic step(input logic r, input logic [2:0] cmd, input logic [3:0] rq,
                        input logic [3:0] msk, input int st, input logic ia,
                        input logic [1:0] id, input string tag);
        logic [14:0] obs;
        logic [14:0] exp;
        string       t;
        rst      = r;
        id_cmd   = cmd;
        irq      = rq;
        irq_mask = msk;
        exp_q.push_back(exp_vec(st, ia, id));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        obs = {ins_clr, ins_cls, ctl_clr, ctl_cls, ex_ctl_clr, pc_prectl, is_nop, busy,
               iack, irq_id};
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", t, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        id_cmd   = 3'd0;
        irq      = 4'd0;
        irq_mask = 4'd0;

        // Reset held two cycles, then one RST cycle shows before IDLE.
        step(1, 0, 0, 0, S_RST, 0, 0, "reset_hold0");
        step(1, 0, 0, 0, S_RST, 0, 0, "reset_hold1");
        step(0, 0, 0, 0, S_IDLE, 0, 0, "reset_to_idle");

        // Multiply: 34 stall cycles; commands during the stall are ignored.
        step(0, 2, 0, 0, S_DLY, 0, 0, "mul_start");
        for (int k = 0; k < 33; k++) step(0, 1, 4'b0010, 0, S_DLY, 0, 0, "mul_dly");
        step(0, 0, 0, 0, S_IDLE, 0, 0, "mul_end");
`ifdef PIPE_HAZARD_PERF_EN
        n_vec++;
        assert (stall_cnt === 32'd34) else begin
            n_miss++;
            $error("FAIL perf_mul observed=%0d expected=34", stall_cnt);
        end
`endif

        // Divide: 36 stall cycles.
        step(0, 3, 0, 0, S_DLY, 0, 0, "div_start");
        for (int k = 0; k < 35; k++) step(0, 0, 0, 0, S_DLY, 0, 0, "div_dly");
        step(0, 0, 0, 0, S_IDLE, 0, 0, "div_end");

        // Priority: lines 1 and 3 pending -> line 1; no nesting until RET.
        step(0, 0, 4'b1010, 0, S_IRQ, 1, 1, "irq_prio");
        step(0, 0, 4'b0001, 0, S_IDLE, 1, 1, "irq_after");
        step(0, 0, 4'b0001, 0, S_IDLE, 1, 1, "irq_no_nest");
        step(0, 4, 4'b0001, 0, S_RET, 1, 1, "ret_enter");
        step(0, 0, 4'b0001, 0, S_IDLE, 0, 1, "ret_clears_iack");
        step(0, 0, 4'b0001, 0, S_IRQ, 1, 0, "irq_line0");
        step(0, 0, 0, 0, S_IDLE, 1, 0, "irq0_idle");
        step(0, 4, 0, 0, S_RET, 1, 0, "ret0_enter");
        step(0, 0, 0, 0, S_IDLE, 0, 0, "ret0_done");

        // Mask suppresses a line; irq beats a simultaneous LD command.
        step(0, 0, 4'b0001, 4'b0001, S_IDLE, 0, 0, "masked");
        step(0, 5, 4'b0100, 4'b0001, S_IRQ, 1, 2, "irq_beats_ld");
        step(0, 0, 0, 0, S_IDLE, 1, 2, "irq2_idle");
        step(0, 4, 0, 0, S_RET, 1, 2, "ret2_enter");
        step(0, 0, 0, 0, S_IDLE, 0, 2, "ret2_done_id_held");

        // LD flush alone.
        step(0, 5, 0, 0, S_LD, 0, 2, "ld");
        step(0, 0, 0, 0, S_IDLE, 0, 2, "ld_end");

        // CUR then NOI; irq raised in NOI waits for IDLE.
        step(0, 1, 0, 0, S_CUR, 0, 2, "cur");
        step(0, 0, 4'b0001, 0, S_NOI, 0, 2, "cur_to_noi");
        step(0, 0, 4'b0001, 0, S_IDLE, 0, 2, "noi_ignores_irq");
        step(0, 0, 4'b0001, 0, S_IRQ, 1, 0, "irq_in_idle");
        step(0, 0, 0, 0, S_IDLE, 1, 0, "irq_cur_idle");
        step(0, 4, 0, 0, S_RET, 1, 0, "ret3_enter");
        step(0, 0, 0, 0, S_IDLE, 0, 0, "ret3_done");

        // NOI command keeps NOI and blocks interrupts; reserved code acts as NOP.
        step(0, 6, 0, 0, S_NOI, 0, 0, "noi_cmd");
        step(0, 6, 4'b1000, 0, S_NOI, 0, 0, "noi_hold");
        step(0, 7, 0, 0, S_IDLE, 0, 0, "reserved_nop");

        // Reset in cycle 10 of a MUL stall taken while iack is set.
        step(0, 0, 4'b1000, 0, S_IRQ, 1, 3, "irq_line3");
        step(0, 0, 0, 0, S_IDLE, 1, 3, "irq3_idle");
        step(0, 2, 0, 0, S_DLY, 1, 3, "mul2_start");
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, S_DLY, 1, 3, "mul2_dly");
        step(1, 0, 0, 0, S_RST, 0, 0, "rst_mid_dly");
`ifdef PIPE_HAZARD_PERF_EN
        n_vec++;
        assert (stall_cnt === 32'd0) else begin
            n_miss++;
            $error("FAIL perf_rst observed=%0d expected=0", stall_cnt);
        end
`endif
        step(0, 0, 0, 0, S_IDLE, 0, 0, "rst_release");
        step(0, 0, 0, 0, S_IDLE, 0, 0, "idle_settle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
